// File: rtl/wb_merge_unit_pkg.sv
// Shared types and default sizes for the writeback merge unit.
// Pure declarations; no logic or state.
// Backpressure: n/a.
package wb_merge_unit_pkg;

    localparam int WB_XLEN           = 32;
    localparam int WB_REG_ADDR_WIDTH = 5;
    localparam int WB_NUM_CH         = 2;
    localparam int WB_FIFO_DEPTH     = 4;

    // One queued register-file write: destination plus result.
    typedef struct packed {
        logic [WB_REG_ADDR_WIDTH-1:0] rd_addr;
        logic [WB_XLEN-1:0]           data;
    } wb_req_t;

endpackage

// File: rtl/wb_merge_unit_if.sv
// Bundle of pipe, channel-completion and writeback signals of the merge unit.
// Wires only; master is the surrounding pipeline, slave is the merge unit.
// Backpressure: ch_ready per channel; pipe_stall toward the pipeline.
interface wb_merge_unit_if
    import wb_merge_unit_pkg::*;
#(
    parameter int XLEN           = WB_XLEN,
    parameter int REG_ADDR_WIDTH = WB_REG_ADDR_WIDTH,
    parameter int NUM_CH         = WB_NUM_CH
);
    logic                             pipe_valid;
    logic                             pipe_reg_write;
    logic [REG_ADDR_WIDTH-1:0]        pipe_rd_addr;
    logic [XLEN-1:0]                  pipe_data;
    logic [NUM_CH-1:0]                ch_valid;
    logic [NUM_CH-1:0]                ch_ready;
    logic [NUM_CH*REG_ADDR_WIDTH-1:0] ch_rd_addr;
    logic [NUM_CH*XLEN-1:0]           ch_data;
    logic                             wb_reg_write;
    logic [REG_ADDR_WIDTH-1:0]        wb_rd_addr;
    logic [XLEN-1:0]                  wb_write_data;
    logic [NUM_CH-1:0]                ch_pending;
    logic                             pipe_stall;

    modport master (
        output pipe_valid, pipe_reg_write, pipe_rd_addr, pipe_data,
        output ch_valid, ch_rd_addr, ch_data,
        input  ch_ready, wb_reg_write, wb_rd_addr, wb_write_data,
        input  ch_pending, pipe_stall
    );

    modport slave (
        input  pipe_valid, pipe_reg_write, pipe_rd_addr, pipe_data,
        input  ch_valid, ch_rd_addr, ch_data,
        output ch_ready, wb_reg_write, wb_rd_addr, wb_write_data,
        output ch_pending, pipe_stall
    );

endinterface

// File: rtl/wb_merge_unit_ch_fifo.sv
// Single-channel synchronous FIFO of writeback requests (wrap-bit pointers).
// Latency: a push is visible at the head on the cycle after the push edge.
// Backpressure: full refuses pushes; a same-cycle pop does not free a slot.
module wb_ch_fifo
    import wb_merge_unit_pkg::*;
#(
    parameter type req_t = wb_req_t,
    parameter int  DEPTH = WB_FIFO_DEPTH,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        push,
    input  req_t        push_req,
    input  logic        pop,
    output req_t        pop_req,
    output logic        full,
    output logic        empty,
    output logic [AW:0] count
);
    req_t        mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;

    // Same slot, opposite lap: the writer is a whole buffer ahead.
    assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign empty   = (wr_ptr == rd_ptr);
    assign count   = wr_ptr - rd_ptr;
    assign pop_req = mem[rd_ptr[AW-1:0]];

    // Pointer advance; reset discards everything queued.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop && !empty)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage write; contents need no reset since pointers gate visibility.
    always_ff @(posedge clk) begin
        if (push && !full)
            mem[wr_ptr[AW-1:0]] <= push_req;
    end

endmodule

// File: rtl/wb_merge_unit.sv
// Merges the in-order MEM/WB write with per-channel long-latency completions.
// Latency: selected entry is on wb_* one edge later; channel push to write >= 2 edges.
// Backpressure: per-channel ch_ready = !full; WB_STARVE_GUARD_EN adds pipe_stall.
module wb_merge_unit
    import wb_merge_unit_pkg::*;
#(
    parameter int XLEN           = WB_XLEN,
    parameter int REG_ADDR_WIDTH = WB_REG_ADDR_WIDTH,
    parameter int NUM_CH         = WB_NUM_CH,
    parameter int FIFO_DEPTH     = WB_FIFO_DEPTH
`ifdef WB_STARVE_GUARD_EN
   ,parameter int STARVE_LIMIT   = 8
`endif
) (
    input logic            clk,
    input logic            reset,
    wb_merge_unit_if.slave bus
);
    localparam int RR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int AW   = $clog2(FIFO_DEPTH);

    typedef struct packed {
        logic [REG_ADDR_WIDTH-1:0] rd_addr;
        logic [XLEN-1:0]           data;
    } req_t;

    logic                      init_done;
    logic [RR_W-1:0]           rr_ptr;
    logic [NUM_CH-1:0]         fifo_full;
    logic [NUM_CH-1:0]         fifo_empty;
    logic [NUM_CH-1:0]         fifo_push;
    logic [NUM_CH-1:0]         fifo_pop;
    logic [NUM_CH-1:0]         ready_w;
    logic [NUM_CH-1:0]         pending_w;
    req_t                      fifo_out [NUM_CH];
    logic                      pipe_hit;
    logic                      sel_valid;
    req_t                      sel_req;
    logic [RR_W-1:0]           winner;
    logic                      any_pop;
    logic                      wb_we_q;
    logic [REG_ADDR_WIDTH-1:0] wb_rd_q;
    logic [XLEN-1:0]           wb_data_q;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        req_t        in_req;
        logic [AW:0] count;

        assign in_req.rd_addr = bus.ch_rd_addr[i*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];
        assign in_req.data    = bus.ch_data[i*XLEN +: XLEN];
        // Held low until the first edge after reset so producers see a clean start.
        assign ready_w[i]     = init_done & ~fifo_full[i];
        // x0 writes complete the handshake but are dropped here.
        assign fifo_push[i]   = bus.ch_valid[i] & ready_w[i] & (in_req.rd_addr != '0);
        assign pending_w[i]   = (count != '0);

        wb_ch_fifo #(
            .req_t (req_t),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk      (clk),
            .reset    (reset),
            .push     (fifo_push[i]),
            .push_req (in_req),
            .pop      (fifo_pop[i]),
            .pop_req  (fifo_out[i]),
            .full     (fifo_full[i]),
            .empty    (fifo_empty[i]),
            .count    (count)
        );
    end

    assign bus.ch_ready   = ready_w;
    assign bus.ch_pending = pending_w;
    assign pipe_hit       = bus.pipe_valid & bus.pipe_reg_write & (bus.pipe_rd_addr != '0);
    assign any_pop        = |fifo_pop;

    // Pipe first; otherwise first non-empty FIFO at/after rr_ptr, then wrap to the low ones.
    always_comb begin
        sel_valid = 1'b0;
        sel_req   = '0;
        winner    = '0;
        fifo_pop  = '0;
        if (pipe_hit) begin
            sel_valid       = 1'b1;
            sel_req.rd_addr = bus.pipe_rd_addr;
            sel_req.data    = bus.pipe_data;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (!sel_valid && !fifo_empty[i] && (i >= int'(rr_ptr))) begin
                    sel_valid   = 1'b1;
                    sel_req     = fifo_out[i];
                    winner      = RR_W'(i);
                    fifo_pop[i] = 1'b1;
                end
            end
            for (int i = 0; i < NUM_CH; i++) begin
                if (!sel_valid && !fifo_empty[i]) begin
                    sel_valid   = 1'b1;
                    sel_req     = fifo_out[i];
                    winner      = RR_W'(i);
                    fifo_pop[i] = 1'b1;
                end
            end
        end
    end

    // Registered write port; address/data hold when nothing is selected.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            init_done <= 1'b0;
            rr_ptr    <= '0;
            wb_we_q   <= 1'b0;
            wb_rd_q   <= '0;
            wb_data_q <= '0;
        end else begin
            init_done <= 1'b1;
            wb_we_q   <= sel_valid;
            if (sel_valid) begin
                wb_rd_q   <= sel_req.rd_addr;
                wb_data_q <= sel_req.data;
            end
            if (any_pop) begin
                if (winner == RR_W'(NUM_CH - 1))
                    rr_ptr <= '0;
                else
                    rr_ptr <= winner + 1'b1;
            end
        end
    end

    assign bus.wb_reg_write  = wb_we_q;
    assign bus.wb_rd_addr    = wb_rd_q;
    assign bus.wb_write_data = wb_data_q;

`ifdef WB_STARVE_GUARD_EN
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic [SW-1:0] starve_cnt;
    logic [SW-1:0] starve_nxt;
    logic          stall_q;

    // Count cycles with queued work but no pop; any pop restarts the count.
    always_comb begin
        starve_nxt = starve_cnt;
        if (any_pop)
            starve_nxt = '0;
        else if ((|pending_w) && (starve_cnt != SW'(STARVE_LIMIT)))
            starve_nxt = starve_cnt + 1'b1;
    end

    // Stall is raised on the edge the count saturates and dropped on the next pop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starve_cnt <= '0;
            stall_q    <= 1'b0;
        end else begin
            starve_cnt <= starve_nxt;
            stall_q    <= (starve_nxt == SW'(STARVE_LIMIT));
        end
    end

    assign bus.pipe_stall = stall_q;
`else
    assign bus.pipe_stall = 1'b0;
`endif

endmodule

// File: tb/tb_wb_merge_unit.sv
// Directed bench for wb_merge_unit: reset, pipe priority, round-robin, full FIFO, x0, starvation.
// Inputs change 1 time unit after each rising edge; outputs are checked at the same point.
// Backpressure is observed through ch_ready and pipe_stall.
module tb_wb_merge_unit;

`ifdef WB_STARVE_GUARD_EN
    localparam logic GUARD = 1'b1;
`else
    localparam logic GUARD = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    wb_merge_unit_if #(.XLEN(32), .REG_ADDR_WIDTH(5), .NUM_CH(2)) bus ();

    wb_merge_unit #(
        .XLEN           (32),
        .REG_ADDR_WIDTH (5),
        .NUM_CH         (2),
        .FIFO_DEPTH     (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_pipe(input logic v, input logic we, input logic [4:0] rd, input logic [31:0] d);
        bus.pipe_valid     = v;
        bus.pipe_reg_write = we;
        bus.pipe_rd_addr   = rd;
        bus.pipe_data      = d;
    endtask

    task automatic set_ch(input int ch, input logic v, input logic [4:0] rd, input logic [31:0] d);
        bus.ch_valid[ch]            = v;
        bus.ch_rd_addr[ch*5 +: 5]   = rd;
        bus.ch_data[ch*32 +: 32]    = d;
    endtask

    initial begin
        logic [4:0]  rr_rd   [4];
        logic [31:0] rr_data [4];
        rr_rd   = '{5'd1, 5'd3, 5'd2, 5'd4};
        rr_data = '{32'h11, 32'h33, 32'h22, 32'h44};

        // ---- reset held with channels requesting
        reset = 1'b0;
        set_pipe(1'b0, 1'b0, 5'd0, 32'h0);
        bus.ch_valid   = 2'b11;
        bus.ch_rd_addr = '0;
        bus.ch_data    = '0;
        step();
        step();
        check("rst_ch_ready",   64'(bus.ch_ready), 64'b00);
        check("rst_wb_we",      64'(bus.wb_reg_write), 64'd0);
        check("rst_wb_rd",      64'(bus.wb_rd_addr), 64'd0);
        check("rst_wb_data",    64'(bus.wb_write_data), 64'd0);
        check("rst_pending",    64'(bus.ch_pending), 64'b00);
        check("rst_stall",      64'(bus.pipe_stall), 64'd0);
        bus.ch_valid = 2'b00;
        reset        = 1'b1;
        check("rel_ready_pre",  64'(bus.ch_ready), 64'b00);
        step();
        check("rel_ready",      64'(bus.ch_ready), 64'b11);

        // ---- pipe priority over a queued ch0 entry
        set_pipe(1'b1, 1'b1, 5'd5, 32'hA);
        set_ch(0, 1'b1, 5'd7, 32'hB);
        step();
        bus.ch_valid = 2'b00;
        check("pp_we1",         64'(bus.wb_reg_write), 64'd1);
        check("pp_rd1",         64'(bus.wb_rd_addr), 64'd5);
        check("pp_data1",       64'(bus.wb_write_data), 64'hA);
        check("pp_pend1",       64'(bus.ch_pending), 64'b01);
        step();
        check("pp_rd2",         64'(bus.wb_rd_addr), 64'd5);
        check("pp_pend2",       64'(bus.ch_pending), 64'b01);
        step();
        check("pp_rd3",         64'(bus.wb_rd_addr), 64'd5);
        bus.pipe_valid = 1'b0;
        step();
        check("pp_ch_we",       64'(bus.wb_reg_write), 64'd1);
        check("pp_ch_rd",       64'(bus.wb_rd_addr), 64'd7);
        check("pp_ch_data",     64'(bus.wb_write_data), 64'hB);
        check("pp_pend_clr",    64'(bus.ch_pending), 64'b00);
        step();
        check("idle_we",        64'(bus.wb_reg_write), 64'd0);
        check("idle_rd_hold",   64'(bus.wb_rd_addr), 64'd7);

        // ---- reset in mid-operation drops queued entries
        set_pipe(1'b1, 1'b1, 5'd5, 32'hA);
        set_ch(0, 1'b1, 5'd9, 32'h99);
        step();
        bus.ch_valid = 2'b00;
        check("mr_pend",        64'(bus.ch_pending), 64'b01);
        #2 reset = 1'b0;
        #1;
        check("mr_pend_clr",    64'(bus.ch_pending), 64'b00);
        check("mr_we",          64'(bus.wb_reg_write), 64'd0);
        check("mr_ready",       64'(bus.ch_ready), 64'b00);
        bus.pipe_valid = 1'b0;
        step();
        reset = 1'b1;
        step();
        check("mr_ready_back",  64'(bus.ch_ready), 64'b11);
        step();
        check("mr_no_write",    64'(bus.wb_reg_write), 64'd0);

        // ---- round-robin between channels, pipe idle
        set_ch(0, 1'b1, 5'd1, 32'h11);
        set_ch(1, 1'b1, 5'd3, 32'h33);
        step();
        check("rr_first_none",  64'(bus.wb_reg_write), 64'd0);
        check("rr_pend",        64'(bus.ch_pending), 64'b11);
        set_ch(0, 1'b1, 5'd2, 32'h22);
        set_ch(1, 1'b1, 5'd4, 32'h44);
        for (int k = 0; k < 4; k++) begin
            step();
            bus.ch_valid = 2'b00;
            check($sformatf("rr_we%0d", k),   64'(bus.wb_reg_write), 64'd1);
            check($sformatf("rr_rd%0d", k),   64'(bus.wb_rd_addr), 64'(rr_rd[k]));
            check($sformatf("rr_data%0d", k), 64'(bus.wb_write_data), 64'(rr_data[k]));
        end
        step();
        check("rr_done_we",     64'(bus.wb_reg_write), 64'd0);
        check("rr_done_pend",   64'(bus.ch_pending), 64'b00);

        // ---- ch1 fills while pipe is busy; fifth entry waits for a pop
        set_pipe(1'b1, 1'b1, 5'd5, 32'hA);
        for (int k = 0; k < 4; k++) begin
            set_ch(1, 1'b1, 5'(10 + k), 32'h100 + 32'(k));
            step();
        end
        set_ch(1, 1'b1, 5'd14, 32'h104);
        check("full_ready",     64'(bus.ch_ready), 64'b01);
        check("full_pend",      64'(bus.ch_pending), 64'b10);
        step();
        check("full_held",      64'(bus.ch_ready), 64'b01);
        check("full_pipe_rd",   64'(bus.wb_rd_addr), 64'd5);
        bus.pipe_valid = 1'b0;
        step();
        check("full_rd10",      64'(bus.wb_rd_addr), 64'd10);
        check("full_data10",    64'(bus.wb_write_data), 64'h100);
        check("full_ready_back", 64'(bus.ch_ready), 64'b11);
        step();
        bus.ch_valid = 2'b00;
        check("full_rd11",      64'(bus.wb_rd_addr), 64'd11);
        for (int k = 2; k < 5; k++) begin
            step();
            check($sformatf("full_we%0d", k),   64'(bus.wb_reg_write), 64'd1);
            check($sformatf("full_rd%0d", k),   64'(bus.wb_rd_addr), 64'(10 + k));
            check($sformatf("full_data%0d", k), 64'(bus.wb_write_data), 64'h100 + 64'(k));
        end
        step();
        check("full_done_we",   64'(bus.wb_reg_write), 64'd0);

        // ---- x0 destinations never write
        set_pipe(1'b1, 1'b1, 5'd0, 32'hDEAD);
        set_ch(0, 1'b1, 5'd0, 32'hBEEF);
        check("x0_ready",       64'(bus.ch_ready[0]), 64'd1);
        step();
        bus.ch_valid = 2'b00;
        check("x0_we",          64'(bus.wb_reg_write), 64'd0);
        check("x0_pend",        64'(bus.ch_pending), 64'b00);
        check("x0_rd_hold",     64'(bus.wb_rd_addr), 64'd14);
        set_pipe(1'b1, 1'b0, 5'd5, 32'h55);
        step();
        check("nowr_we",        64'(bus.wb_reg_write), 64'd0);
        check("nowr_data_hold", 64'(bus.wb_write_data), 64'h104);
        step();
        check("x0_still_idle",  64'(bus.wb_reg_write), 64'd0);

        // ---- starvation: pipe writes every cycle while ch0 holds one entry
        set_pipe(1'b1, 1'b1, 5'd5, 32'hA);
        set_ch(0, 1'b1, 5'd6, 32'h66);
        step();
        bus.ch_valid = 2'b00;
        repeat (7) step();
        check("st_pre",         64'(bus.pipe_stall), 64'd0);
        step();
        check("st_stall",       64'(bus.pipe_stall), 64'(GUARD));
        check("st_pend",        64'(bus.ch_pending), 64'b01);
        bus.pipe_valid = 1'b0;
        step();
        check("st_we",          64'(bus.wb_reg_write), 64'd1);
        check("st_rd",          64'(bus.wb_rd_addr), 64'd6);
        check("st_data",        64'(bus.wb_write_data), 64'h66);
        check("st_release",     64'(bus.pipe_stall), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
